// File: rtl/lsu.sv
// Load/store unit: turns one core load/store/fence.i request into a single
// word-addressed SPRAM access, waits on memory readiness and reports
// completion with a one-cycle done pulse (plus fault for rejected requests).
module lsu (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic        i_load,
   input  logic        i_store,
   input  logic        i_fence_i,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_fault,
   output logic [31:0] o_rdata,
   output logic        o_dm_ren,
   output logic        o_dm_wen,
   output logic [3:0]  o_dm_ben,
   output logic [13:0] o_dm_addr,
   output logic [31:0] o_dm_wdata,
   output logic        o_fence_i,
   input  logic [31:0] i_dm_rdata,
   input  logic        i_mem_ready
);

   typedef enum logic [2:0] {IDLE, ISSUE, LWAIT, FENCE, FWAIT, DONE} state_t;

   state_t      state, state_nxt;
   logic        accept;
   logic        req_load;
   logic        req_fault;
   logic [2:0]  req_f3;
   logic [1:0]  req_off;
   logic [13:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_ben;
   logic        fw_seen;

   // A request is illegal if its kind is ambiguous, its width code is not a
   // legal RV32I encoding for that kind, it falls outside the 64 KiB window
   // or it is misaligned for its width.
   function automatic logic req_bad(input logic ld, input logic st,
                                    input logic [2:0] f3, input logic [31:0] addr);
      logic bad;
      bad = (ld == st);
      if (st)
         bad = bad | f3[2] | (f3[1:0] == 2'b11);
      else
         bad = bad | (f3[1:0] == 2'b11) | (f3[2] & f3[1]);
      bad = bad | (addr[31:16] != 16'h0);
      bad = bad | ((f3[1:0] == 2'b01) & addr[0]);
      bad = bad | ((f3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
      return bad;
   endfunction

   // Byte lanes touched by a store of the given width at the given offset.
   function automatic logic [3:0] store_ben(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   return 4'b0001 << off;
         2'b01:   return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Store data is replicated across all lanes so the enabled lane always
   // carries the right byte/halfword regardless of offset.
   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   // Right-align the addressed lane, then sign- or zero-extend by width.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0] off,
                                                input logic [2:0] f3);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b100:  return {24'h0, sh[7:0]};
         3'b101:  return {16'h0, sh[15:0]};
         default: return sh;
      endcase
   endfunction

   assign accept = (state == IDLE) & i_valid;

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; fence.i outranks the fault check, which outranks
   // the store/load split.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (i_valid) begin
               if (i_fence_i)                                  state_nxt = FENCE;
               else if (req_bad(i_load, i_store, i_funct3, i_addr)) state_nxt = DONE;
               else                                            state_nxt = ISSUE;
            end
         end
         ISSUE:   if (i_mem_ready) state_nxt = req_load ? LWAIT : DONE;
         LWAIT:   state_nxt = DONE;
         FENCE:   state_nxt = FWAIT;
         FWAIT:   if (fw_seen && i_mem_ready) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Latch the request on accept so address/data/lanes stay stable while stalled.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         req_load  <= 1'b0;
         req_fault <= 1'b0;
         req_f3    <= 3'b000;
         req_off   <= 2'b00;
         req_addr  <= 14'h0;
         req_wdata <= 32'h0;
         req_ben   <= 4'h0;
      end else if (accept) begin
         req_load  <= i_load & ~i_fence_i;
         req_fault <= ~i_fence_i & req_bad(i_load, i_store, i_funct3, i_addr);
         req_f3    <= i_funct3;
         req_off   <= i_addr[1:0];
         req_addr  <= i_addr[15:2];
         req_wdata <= i_store ? store_data(i_funct3, i_wdata) : 32'h0;
         if (i_fence_i || req_bad(i_load, i_store, i_funct3, i_addr))
            req_ben <= 4'h0;
         else if (i_store)
            req_ben <= store_ben(i_funct3, i_addr[1:0]);
         else
            req_ben <= 4'hF;
      end
   end

   // Marks that FWAIT has already lasted one cycle; memory ready only drops
   // one cycle after the fence pulse, so it cannot be trusted before then.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) fw_seen <= 1'b0;
      else       fw_seen <= (state == FWAIT);
   end

   // Load result register; holds its value across store/fence/fault completions.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                o_rdata <= 32'h0;
      else if (state == LWAIT)  o_rdata <= load_extract(i_dm_rdata, req_off, req_f3);
   end

   assign o_busy     = (state != IDLE);
   assign o_done     = (state == DONE);
   assign o_fault    = (state == DONE) & req_fault;
   assign o_dm_ren   = (state == ISSUE) & req_load & i_mem_ready;
   assign o_dm_wen   = (state == ISSUE) & ~req_load & i_mem_ready;
   assign o_dm_ben   = req_ben;
   assign o_dm_addr  = req_addr;
   assign o_dm_wdata = req_wdata;
   assign o_fence_i  = (state == FENCE);

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a table of single requests with hand-computed
// results, plus hand-written stall, fence and reset sequences.
module tb_lsu;

   logic        clk, rst;
   logic        valid, ld, st, fn;
   logic [2:0]  f3;
   logic [31:0] addr, wdata;
   logic        busy, done, fault;
   logic [31:0] rdata;
   logic        ren, wen;
   logic [3:0]  ben;
   logic [13:0] daddr;
   logic [31:0] dwdata;
   logic        fence_o;
   logic [31:0] dm_rdata;
   logic        ready;
   logic [31:0] mem_word;

   int total = 0;
   int passed = 0;

   lsu dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_load(ld), .i_store(st),
      .i_fence_i(fn), .i_funct3(f3), .i_addr(addr), .i_wdata(wdata),
      .o_busy(busy), .o_done(done), .o_fault(fault), .o_rdata(rdata),
      .o_dm_ren(ren), .o_dm_wen(wen), .o_dm_ben(ben), .o_dm_addr(daddr),
      .o_dm_wdata(dwdata), .o_fence_i(fence_o), .i_dm_rdata(dm_rdata),
      .i_mem_ready(ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: read data appears the cycle after a read strobe; junk otherwise.
   always @(posedge clk) dm_rdata <= ren ? mem_word : 32'h5A5A_5A5A;

   typedef struct {
      logic        ld, st;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, mem;
      logic        ex_fault;
      logic [3:0]  ex_ben;
      logic [31:0] ex_wdata;
      logic [13:0] ex_addr;
      logic [31:0] ex_rdata;
      int          ex_lat;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int lat, nren, nwen;
      logic [3:0]  sben;
      logic [31:0] swd, srd;
      logic [13:0] sad;
      logic        sfault;
      v = vecs[idx];
      lat = 0; nren = 0; nwen = 0; sben = 0; swd = 0; sad = 0; srd = 0; sfault = 0;
      mem_word = v.mem;
      valid = 1; ld = v.ld; st = v.st; fn = 0; f3 = v.f3; addr = v.addr; wdata = v.wdata; ready = 1;
      tick();
      valid = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (ren) nren++;
         if (wen) nwen++;
         if (ren | wen) begin sben = ben; swd = dwdata; sad = daddr; end
         if (done) begin lat = k; sfault = fault; srd = rdata; break; end
         tick();
      end
      check($sformatf("v%0d latency", idx), lat, v.ex_lat);
      check($sformatf("v%0d fault", idx), {31'h0, sfault}, {31'h0, v.ex_fault});
      check($sformatf("v%0d ren_count", idx), nren, (v.ld & ~v.ex_fault) ? 1 : 0);
      check($sformatf("v%0d wen_count", idx), nwen, (v.st & ~v.ex_fault) ? 1 : 0);
      check($sformatf("v%0d rdata", idx), srd, v.ex_rdata);
      if (!v.ex_fault) begin
         check($sformatf("v%0d ben", idx), {28'h0, sben}, {28'h0, v.ex_ben});
         check($sformatf("v%0d addr", idx), {18'h0, sad}, {18'h0, v.ex_addr});
         if (v.st) check($sformatf("v%0d wdata", idx), swd, v.ex_wdata);
      end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int fence_cnt;
      int dcyc;
      //        ld   st   f3      addr          wdata         mem           flt  ben   ex_wdata      ex_addr ex_rdata     lat
      vecs[0]  = '{1'b0,1'b1,3'b010,32'h0000_0010,32'hDEADBEEF,32'h0,        1'b0,4'hF,32'hDEADBEEF,14'd4,32'h0000_0000,2};
      vecs[1]  = '{1'b1,1'b0,3'b000,32'h0000_0013,32'h0,        32'h80FF7F01,1'b0,4'hF,32'h0,        14'd4,32'hFFFF_FF80,3};
      vecs[2]  = '{1'b1,1'b0,3'b100,32'h0000_0013,32'h0,        32'h80FF7F01,1'b0,4'hF,32'h0,        14'd4,32'h0000_0080,3};
      vecs[3]  = '{1'b1,1'b0,3'b101,32'h0000_0012,32'h0,        32'h80FF7F01,1'b0,4'hF,32'h0,        14'd4,32'h0000_80FF,3};
      vecs[4]  = '{1'b1,1'b0,3'b001,32'h0000_0012,32'h0,        32'h80FF7F01,1'b0,4'hF,32'h0,        14'd4,32'hFFFF_80FF,3};
      vecs[5]  = '{1'b1,1'b0,3'b010,32'h0000_0010,32'h0,        32'h80FF7F01,1'b0,4'hF,32'h0,        14'd4,32'h80FF_7F01,3};
      vecs[6]  = '{1'b0,1'b1,3'b001,32'h0000_0006,32'h0000_1234,32'h0,        1'b0,4'hC,32'h1234_1234,14'd1,32'h80FF_7F01,2};
      vecs[7]  = '{1'b0,1'b1,3'b000,32'h0000_0005,32'h0000_00AB,32'h0,        1'b0,4'h2,32'hABAB_ABAB,14'd1,32'h80FF_7F01,2};
      vecs[8]  = '{1'b1,1'b0,3'b010,32'h0000_0002,32'h0,        32'h0,        1'b1,4'h0,32'h0,        14'd0,32'h80FF_7F01,1};
      vecs[9]  = '{1'b0,1'b1,3'b010,32'h0001_0000,32'h1111_1111,32'h0,        1'b1,4'h0,32'h0,        14'd0,32'h80FF_7F01,1};
      vecs[10] = '{1'b1,1'b0,3'b011,32'h0000_0000,32'h0,        32'h0,        1'b1,4'h0,32'h0,        14'd0,32'h80FF_7F01,1};
      vecs[11] = '{1'b1,1'b0,3'b000,32'h0000_0001,32'h0,        32'h80FF7F01,1'b0,4'hF,32'h0,        14'd0,32'h0000_007F,3};
      vecs[12] = '{1'b0,1'b1,3'b100,32'h0000_0000,32'h0000_00AB,32'h0,        1'b1,4'h0,32'h0,        14'd0,32'h0000_007F,1};
      vecs[13] = '{1'b1,1'b1,3'b010,32'h0000_0000,32'h0,        32'h0,        1'b1,4'h0,32'h0,        14'd0,32'h0000_007F,1};

      rst = 1; valid = 0; ld = 0; st = 0; fn = 0; f3 = 0; addr = 0; wdata = 0; ready = 1; mem_word = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("reset busy", {31'h0, busy}, 32'h0);
      check("reset done_fault", {30'h0, done, fault}, 32'h0);
      check("reset strobes", {29'h0, ren, wen, fence_o}, 32'h0);
      check("reset ben_addr", {14'h0, ben, daddr}, 32'h0);
      check("reset wdata", dwdata, 32'h0);
      check("reset rdata", rdata, 32'h0);
      tick();

      for (int i = 0; i < 14; i++) run_vec(i);

      // Store stalled by memory for three ISSUE cycles.
      valid = 1; ld = 0; st = 1; fn = 0; f3 = 3'b010; addr = 32'h20; wdata = 32'hCAFE_F00D; ready = 0;
      tick();
      valid = 0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check($sformatf("stall c%0d wen", c), {31'h0, wen}, 32'h0);
         check($sformatf("stall c%0d addr", c), {18'h0, daddr}, 32'd8);
         check($sformatf("stall c%0d busy", c), {31'h0, busy}, 32'h1);
         tick();
      end
      ready = 1;
      @(negedge clk);
      check("stall wen", {31'h0, wen}, 32'h1);
      check("stall wdata", dwdata, 32'hCAFE_F00D);
      check("stall done_early", {31'h0, done}, 32'h0);
      tick();
      @(negedge clk);
      check("stall done", {31'h0, done}, 32'h1);
      tick();
      @(negedge clk);
      check("stall idle", {31'h0, busy}, 32'h0);

      // Fence with ready held high: earliest completion at t+4.
      valid = 1; ld = 0; st = 0; fn = 1; f3 = 0; addr = 0; ready = 1;
      tick();
      valid = 0; fn = 0;
      fence_cnt = 0; dcyc = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (fence_o) fence_cnt++;
         if (done) begin dcyc = k; break; end
         tick();
      end
      check("fence_fast done_cycle", dcyc, 4);
      check("fence_fast pulses", fence_cnt, 1);
      tick();

      // Fence with memory not ready for 5 cycles after the pulse.
      valid = 1; fn = 1;
      tick();
      valid = 0; fn = 0;
      fence_cnt = 0; dcyc = 0;
      for (int k = 1; k <= 15; k++) begin
         if (k >= 2 && k <= 6) ready = 0; else ready = 1;
         @(negedge clk);
         if (fence_o) fence_cnt++;
         if (done) begin dcyc = k; break; end
         tick();
      end
      ready = 1;
      check("fence_slow done_cycle", dcyc, 8);
      check("fence_slow pulses", fence_cnt, 1);
      tick();

      // Reset while in FWAIT.
      valid = 1; fn = 1;
      tick();
      valid = 0; fn = 0;
      tick();
      @(negedge clk);
      check("pre_rst busy", {31'h0, busy}, 32'h1);
      #2 rst = 1;
      #1;
      check("rst busy", {31'h0, busy}, 32'h0);
      check("rst outs", {27'h0, done, fault, ren, wen, fence_o}, 32'h0);
      check("rst rdata", rdata, 32'h0);
      check("rst ben_addr", {14'h0, ben, daddr}, 32'h0);
      tick();
      rst = 0;
      tick();
      @(negedge clk);
      check("post_rst idle", {31'h0, busy}, 32'h0);
      tick();

      // Recovery: a load works normally after the reset.
      vecs[0] = '{1'b1,1'b0,3'b101,32'h0000_0002,32'h0,32'h1234_5678,1'b0,4'hF,32'h0,14'd0,32'h0000_1234,3};
      run_vec(0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
